// File: rtl/debounce_sync3.sv
// rtl/debounce_sync3.sv - three-channel 2-FF synchronizer and debouncer with optional rise strobes
//
// Purpose:
//   Conditions three asynchronous, bouncing board pins into clean,
//   clock-aligned levels. Each channel is independent: a 2-FF synchronizer
//   followed by a mismatch counter that must see DEBOUNCE_CYCLES consecutive
//   cycles of disagreement before the clean level follows the pin.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive mismatching cycles before clean changes (2 .. 2**CNT_W)
//   CNT_W           - width of each per-channel debounce counter
//
// Ports:
//   clk    - system clock
//   rst    - synchronous, active-high reset
//   raw_in - asynchronous pin levels (bit 0 = a, bit 1 = b, bit 2 = c)
//   clean  - debounced levels, same bit order, registered
//   rise   - registered one-cycle pulse on each 0->1 change of clean
//
// Build option:
//   DEBOUNCE_EDGE_EN - when defined the rise registers are compiled in;
//                      when undefined rise is tied to 3'b000.

module debounce_sync3 #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] raw_in,
    output logic [2:0] clean,
    output logic [2:0] rise
);

    localparam int NCH = 3;

    // Terminal count: the edge on which cnt already holds DEBOUNCE_CYCLES-1
    // is the one that moves clean. Fits in CNT_W bits for the legal range.
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchronizer flops: s1 may go metastable, s2 is the first usable copy.
    logic [NCH-1:0] s1_q;
    logic [NCH-1:0] s2_q;

    logic [NCH-1:0] clean_q;
    logic [NCH-1:0] clean_d;

    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    // 2-FF synchronizer, nothing between the two stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw_in;
            s2_q <= s1_q;
        end
    end

    // Per-channel debounce next state. Any cycle of agreement drops the
    // partial count, so only an unbroken run of mismatches moves clean.
    always_comb begin
        clean_d = clean_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_TERM) begin
                    clean_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clean_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            clean_q <= clean_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign clean = clean_q;

`ifdef DEBOUNCE_EDGE_EN
    // Strobe is registered alongside clean so it lines up with the cycle in
    // which the new high level first appears.
    logic [NCH-1:0] rise_q;
    logic [NCH-1:0] rise_d;

    always_comb begin
        rise_d = clean_d & ~clean_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
        end else begin
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;
`else
    assign rise = '0;
`endif

endmodule

// File: tb/tb_debounce_sync3.sv
// tb/tb_debounce_sync3.sv - scoreboard testbench for debounce_sync3

module tb_debounce_sync3;

    localparam int D = 4;
    localparam int W = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] raw_in;
    logic [2:0] clean;
    logic [2:0] rise;

    always #5 clk = ~clk;

    debounce_sync3 #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .raw_in(raw_in),
        .clean (clean),
        .rise  (rise)
    );

    typedef struct packed {
        logic [2:0] clean;
        logic [2:0] rise;
    } exp_t;

    exp_t q[$];

    int tests    = 0;
    int fails    = 0;
    bit done     = 1'b0;
    bit mon_done = 1'b0;

    // Reference model: pin values reach the comparison point two edges late;
    // a channel's clean level follows once it has disagreed with the pin for
    // D consecutive edges.
    logic [2:0] m_clean;
    int         m_run [3];
    logic [2:0] m_dly [$];

    function automatic void model_step(input logic r, input logic [2:0] raw);
        exp_t       e;
        logic [2:0] x;
        logic [2:0] rs;
        rs = 3'b000;
        if (r) begin
            m_dly   = {3'b000, 3'b000};
            m_clean = 3'b000;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
        end else begin
            x = m_dly.pop_front();
            m_dly.push_back(raw);
            for (int i = 0; i < 3; i++) begin
                if (x[i] == m_clean[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == D) begin
                        m_clean[i] = x[i];
                        m_run[i]   = 0;
                        rs[i]      = x[i];
                    end
                end
            end
        end
        e.clean = m_clean;
`ifdef DEBOUNCE_EDGE_EN
        e.rise = rs;
`else
        e.rise = 3'b000;
`endif
        q.push_back(e);
    endfunction

    task automatic cyc(input logic r, input logic [2:0] v);
        @(negedge clk);
        rst    = r;
        raw_in = v;
        model_step(r, v);
    endtask

    task automatic hold(input logic r, input logic [2:0] v, input int n);
        for (int k = 0; k < n; k++) cyc(r, v);
    endtask

    // Monitor: one expected entry per rising edge, compared after the edge.
    initial begin : monitor
        exp_t e;
        logic exp_ds;
        logic act_ds;
        while (!(done && q.size() == 0)) begin
            @(posedge clk);
            #2;
            if (q.size() == 0) begin
                if (!done) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_empty at %0t: got no entry, required one", $time);
                end
            end else begin
                e = q.pop_front();
                tests++;
                if (clean !== e.clean) begin
                    fails++;
                    $display("FAIL clean at %0t: got %b, required %b", $time, clean, e.clean);
                end
                tests++;
                if (rise !== e.rise) begin
                    fails++;
                    $display("FAIL rise at %0t: got %b, required %b", $time, rise, e.rise);
                end
                exp_ds = (e.clean[0] | e.clean[1]) & e.clean[2];
                act_ds = (clean[0] | clean[1]) & clean[2];
                tests++;
                if (act_ds !== exp_ds) begin
                    fails++;
                    $display("FAIL downstream at %0t: got %b, required %b", $time, act_ds, exp_ds);
                end
            end
        end
        mon_done = 1'b1;
    end

    initial begin : driver
        int len;
        logic [2:0] v;
        logic r;

        rst    = 1'b1;
        raw_in = 3'b000;
        model_step(1'b1, 3'b000);

        // Pin held high through reset, then released from reset
        hold(1'b1, 3'b111, 2);
        hold(1'b0, 3'b111, 10);

        // Clean step on channel a
        hold(1'b1, 3'b000, 2);
        hold(1'b0, 3'b001, 10);

        // Bounce on channel b: 3-cycle highs never reach D
        hold(1'b1, 3'b000, 2);
        for (int k = 0; k < 6; k++) begin
            hold(1'b0, 3'b010, 3);
            cyc(1'b0, 3'b000);
        end
        hold(1'b0, 3'b000, 8);

        // Reset in the middle of a count on channel c
        hold(1'b1, 3'b000, 2);
        hold(1'b0, 3'b100, 4);
        hold(1'b1, 3'b100, 2);
        hold(1'b0, 3'b100, 10);

        // Downstream (a|b)&c: assert then release c
        hold(1'b1, 3'b000, 2);
        hold(1'b0, 3'b101, 10);
        hold(1'b0, 3'b001, 10);

        // Randomized segments of held levels with occasional resets
        for (int s = 0; s < 300; s++) begin
            v   = 3'($urandom_range(0, 7));
            len = int'($urandom_range(1, 8));
            r   = ($urandom_range(0, 29) == 0);
            hold(r, v, len);
        end
        done = 1'b1;

        for (int k = 0; k < 50 && !mon_done; k++) @(posedge clk);
        if (!mon_done) begin
            tests++;
            fails++;
            $display("FAIL monitor_timeout: got %0d entries pending, required 0", q.size());
        end
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
